// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB first,
// producing a WIDTH-bit result with unsigned carry-out and signed overflow.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);
   localparam int DW = DIGIT + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  op_a, op_b;
   logic              carry;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  sum_q;
   logic              cout_q, ovf_q;
   logic              accept, last;
   logic [DIGIT:0]    dsum;
   logic [WIDTH-1:0]  sum_nxt;
   logic              ovf_nxt;

   assign accept = start && (state != RUN);
   assign last   = (cnt == CW'(N - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: default assignment first so no path through the case leaves
   // state_nxt unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // One digit of the ripple: low DIGIT bits of each operand plus the carry.
   always_comb begin
      dsum    = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + DW'(carry);
      sum_nxt = WIDTH'({dsum[DIGIT-1:0], sum_q} >> DIGIT);
      // Carry into the MSB is recovered as a ^ b ^ sum at that bit position.
      ovf_nxt = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
   end

   // NOTE: datapath registers are reset alongside the FSM so outputs read 0
   // during reset and no X can propagate into the first result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a   <= '0;
         op_b   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         op_a  <= a;
         op_b  <= b ^ {WIDTH{sub}};
         carry <= sub;
         cnt   <= '0;
      end else if (state == RUN) begin
         op_a  <= op_a >> DIGIT;
         op_b  <= op_b >> DIGIT;
         carry <= dsum[DIGIT];
         sum_q <= sum_nxt;
         cnt   <= cnt + CW'(1);
         if (last) begin
            cout_q <= dsum[DIGIT];
            ovf_q  <= ovf_nxt;
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
